// File: rtl/hilo_mult_unit.sv
// Iterative radix-2 multiply/accumulate unit with the HI/LO register pair (mult, multu, madd, msub, mul, mthi, mtlo).
// Latency: mthi/mtlo land on the accept edge; multiplies commit WIDTH+1 edges after accept, with a one-cycle Done pulse.
// Backpressure: Busy is high while a multiply is in flight, and any Start seen during that time is dropped without sampling operands.
module hilo_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [4:0]       ALUCtl,
  input  logic             HiLoWrite,
  input  logic             MultBit,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] MulResult,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  localparam logic [4:0] OP_MTHI  = 5'b10001;
  localparam logic [4:0] OP_MTLO  = 5'b10011;
  localparam logic [4:0] OP_MULT  = 5'b00101;
  localparam logic [4:0] OP_MULTU = 5'b01100;
  localparam logic [4:0] OP_MADD  = 5'b11010;
  localparam logic [4:0] OP_MSUB  = 5'b01101;
  localparam logic [4:0] OP_MUL   = 5'b11000;

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // How the finished product is folded into architectural state.
  typedef enum logic [1:0] {
    K_MULT = 2'd0,   // mult and multu: overwrite {Hi,Lo}
    K_MADD = 2'd1,
    K_MSUB = 2'd2,
    K_MUL  = 2'd3    // GPR result only
  } kind_t;

  typedef struct packed {
    logic  wr_hi;       // mthi
    logic  wr_lo;       // mtlo
    logic  mul_go;      // one of the five multiply flavours
    logic  is_signed;   // operands are two's complement
    kind_t kind;
  } dec_t;

  state_t          state;
  kind_t           kind_q;
  logic            sign_q;
  logic [CW-1:0]   count;
  logic [PW-1:0]   mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]   acc;

  dec_t            dec;
  logic            accept;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic            op_sign;
  logic [PW-1:0]   prod;
  logic [PW-1:0]   hilo;

  // Decode the incoming op; qualifiers must accompany the op code or nothing happens.
  always_comb begin
    dec = '{wr_hi: 1'b0, wr_lo: 1'b0, mul_go: 1'b0, is_signed: 1'b0, kind: K_MULT};
    case (ALUCtl)
      OP_MTHI:  dec.wr_hi = HiLoWrite;
      OP_MTLO:  dec.wr_lo = HiLoWrite;
      OP_MULT: begin
        dec.mul_go    = HiLoWrite;
        dec.is_signed = 1'b1;
        dec.kind      = K_MULT;
      end
      OP_MULTU: begin
        dec.mul_go    = HiLoWrite;
        dec.is_signed = 1'b0;
        dec.kind      = K_MULT;
      end
      OP_MADD: begin
        dec.mul_go    = HiLoWrite;
        dec.is_signed = 1'b1;
        dec.kind      = K_MADD;
      end
      OP_MSUB: begin
        dec.mul_go    = HiLoWrite;
        dec.is_signed = 1'b1;
        dec.kind      = K_MSUB;
      end
      OP_MUL: begin
        dec.mul_go    = MultBit;
        dec.is_signed = 1'b1;
        dec.kind      = K_MUL;
      end
      default: dec.mul_go = 1'b0;
    endcase
  end

  // Operand magnitudes and result sign; -2^(WIDTH-1) negates to itself, which is the correct unsigned magnitude.
  always_comb begin
    accept  = Start && (state == ST_IDLE);
    a_mag   = (dec.is_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
    b_mag   = (dec.is_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
    op_sign = dec.is_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
  end

  // Re-apply the sign to the unsigned magnitude and present the current {Hi,Lo} for accumulation.
  always_comb begin
    prod = sign_q ? (~acc + 1'b1) : acc;
    hilo = {Hi, Lo};
  end

  // Shift-add datapath: one multiplier bit per RUN cycle, loaded fresh on every accepted multiply.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign_q <= 1'b0;
      kind_q <= K_MULT;
    end else if (accept && dec.mul_go) begin
      mcand  <= {{WIDTH{1'b0}}, a_mag};
      mplier <= b_mag;
      acc    <= '0;
      sign_q <= op_sign;
      kind_q <= dec.kind;
    end else if (state == ST_RUN) begin
      acc    <= mplier[0] ? (acc + mcand) : acc;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  // Control FSM with registered Busy/Done and the architectural HI/LO/MulResult registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      Busy      <= 1'b0;
      Done      <= 1'b0;
      Hi        <= '0;
      Lo        <= '0;
      MulResult <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Start) begin
            if (dec.wr_hi) begin
              Hi <= A;
            end
            if (dec.wr_lo) begin
              Lo <= A;
            end
            if (dec.mul_go) begin
              state <= ST_RUN;
              count <= CW'(WIDTH);
              Busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          case (kind_q)
            K_MULT:  {Hi, Lo} <= prod;
            K_MADD:  {Hi, Lo} <= hilo + prod;
            K_MSUB:  {Hi, Lo} <= hilo - prod;
            default: MulResult <= prod[WIDTH-1:0];
          endcase
          Done  <= 1'b1;
          Busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit with a cycle-level reference model.
// Latency: expected results land WIDTH+1 edges after accept in the model.
// Backpressure: model drops Start while an op is pending, as the unit must.
module tb_hilo_mult_unit;

  localparam int WIDTH = 32;

  localparam logic [4:0] C_MTHI  = 5'b10001;
  localparam logic [4:0] C_MTLO  = 5'b10011;
  localparam logic [4:0] C_MULT  = 5'b00101;
  localparam logic [4:0] C_MULTU = 5'b01100;
  localparam logic [4:0] C_MADD  = 5'b11010;
  localparam logic [4:0] C_MSUB  = 5'b01101;
  localparam logic [4:0] C_MUL   = 5'b11000;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [4:0]  ALUCtl = 5'b0;
  logic        HiLoWrite = 1'b0;
  logic        MultBit = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Busy;
  logic        Done;
  logic [31:0] MulResult;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int vectors = 0;
  int errors  = 0;

  hilo_mult_unit #(.WIDTH(WIDTH)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .ALUCtl    (ALUCtl),
    .HiLoWrite (HiLoWrite),
    .MultBit   (MultBit),
    .A         (A),
    .B         (B),
    .Busy      (Busy),
    .Done      (Done),
    .MulResult (MulResult),
    .Hi        (Hi),
    .Lo        (Lo)
  );

  always #5 Clk = ~Clk;

  // ---------------- reference model ----------------
  logic [31:0] m_hi, m_lo, m_mr;
  logic [63:0] m_p;
  bit          m_pend, m_done, m_init;
  int          m_kind;   // 0 overwrite, 1 add, 2 subtract, 3 GPR
  int          edge_n = 0;
  int          due = 0;

  function automatic logic [63:0] smul(logic [31:0] a, logic [31:0] b);
    longint x;
    x = longint'($signed(a)) * longint'($signed(b));
    return x;
  endfunction

  function automatic logic [63:0] umul(logic [31:0] a, logic [31:0] b);
    logic [63:0] x;
    x = {32'b0, a} * {32'b0, b};
    return x;
  endfunction

  always @(posedge Clk) begin
    if (Reset) begin
      m_hi = '0; m_lo = '0; m_mr = '0;
      m_pend = 1'b0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_pend) begin
        if (edge_n == due) begin
          case (m_kind)
            0: {m_hi, m_lo} = m_p;
            1: {m_hi, m_lo} = {m_hi, m_lo} + m_p;
            2: {m_hi, m_lo} = {m_hi, m_lo} - m_p;
            default: m_mr = m_p[31:0];
          endcase
          m_pend = 1'b0;
          m_done = 1'b1;
        end
      end else if (Start) begin
        m_kind = -1;
        case (ALUCtl)
          C_MTHI:  if (HiLoWrite) m_hi = A;
          C_MTLO:  if (HiLoWrite) m_lo = A;
          C_MULT:  if (HiLoWrite) begin m_kind = 0; m_p = smul(A, B); end
          C_MULTU: if (HiLoWrite) begin m_kind = 0; m_p = umul(A, B); end
          C_MADD:  if (HiLoWrite) begin m_kind = 1; m_p = smul(A, B); end
          C_MSUB:  if (HiLoWrite) begin m_kind = 2; m_p = smul(A, B); end
          C_MUL:   if (MultBit)   begin m_kind = 3; m_p = smul(A, B); end
          default: m_kind = -1;
        endcase
        if (m_kind >= 0) begin
          m_pend = 1'b1;
          due    = edge_n + WIDTH + 1;
        end
      end
    end
    m_init = 1'b1;
    edge_n++;
  end

  // Every cycle after the first edge, all outputs must match the model.
  always @(posedge Clk) begin
    #2;
    if (m_init) begin
      vectors++;
      if (Busy !== m_pend || Done !== m_done || Hi !== m_hi || Lo !== m_lo || MulResult !== m_mr) begin
        errors++;
        $display("FAIL cycle %0d busy/done/hi/lo/mulresult got %b %b %h %h %h expected %b %b %h %h %h",
                 edge_n, Busy, Done, Hi, Lo, MulResult, m_pend, m_done, m_hi, m_lo, m_mr);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; Start is seen by exactly one rising edge.
  task automatic issue(logic [4:0] c, logic h, logic m, logic [31:0] a, logic [31:0] b);
    Start = 1'b1; ALUCtl = c; HiLoWrite = h; MultBit = m; A = a; B = b;
    @(negedge Clk);
    Start = 1'b0; HiLoWrite = 1'b0; MultBit = 1'b0;
    A = 32'hDEADBEEF; B = 32'hCAFEF00D;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (Done !== 1'b1 && n < 60) begin
      @(negedge Clk);
      n++;
    end
    check("done_seen", {63'b0, Done}, 64'd1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  initial begin
    int n;
    repeat (3) @(negedge Clk);
    check("reset_busy", {63'b0, Busy}, 64'd0);
    check("reset_done", {63'b0, Done}, 64'd0);
    check("reset_hi", {32'b0, Hi}, 64'd0);
    check("reset_lo", {32'b0, Lo}, 64'd0);
    check("reset_mulresult", {32'b0, MulResult}, 64'd0);
    Reset = 1'b0;
    @(negedge Clk);

    issue(C_MULT, 1, 0, 32'hFFFFFFFF, 32'h00000002);
    wait_done(n);
    check("mult_latency", 64'(n), 64'd33);
    check("mult_hi", {32'b0, Hi}, 64'hFFFFFFFF);
    check("mult_lo", {32'b0, Lo}, 64'hFFFFFFFE);
    @(negedge Clk);
    check("done_single_pulse", {63'b0, Done}, 64'd0);

    issue(C_MULTU, 1, 0, 32'hFFFFFFFF, 32'h00000002);
    wait_done(n);
    check("multu_hi", {32'b0, Hi}, 64'h00000001);
    check("multu_lo", {32'b0, Lo}, 64'hFFFFFFFE);

    issue(C_MULT, 1, 0, 32'h80000000, 32'h80000000);
    wait_done(n);
    check("mult_minneg_hi", {32'b0, Hi}, 64'h40000000);
    check("mult_minneg_lo", {32'b0, Lo}, 64'h00000000);

    // Missing qualifiers and unknown codes must do nothing.
    issue(C_MULT, 0, 0, 32'd5, 32'd5);
    check("unqualified_busy", {63'b0, Busy}, 64'd0);
    issue(C_MUL, 1, 0, 32'd5, 32'd5);
    check("mul_no_multbit_busy", {63'b0, Busy}, 64'd0);
    issue(5'b00000, 1, 1, 32'd5, 32'd5);
    check("unknown_op_hi", {32'b0, Hi}, 64'h40000000);

    pulse_reset();
    issue(C_MTLO, 1, 0, 32'h0000000A, 32'd0);
    check("mtlo_lo", {32'b0, Lo}, 64'h0000000A);
    issue(C_MADD, 1, 0, 32'd3, 32'd4);
    wait_done(n);
    check("madd_lo", {32'b0, Lo}, 64'h00000016);
    check("madd_hi", {32'b0, Hi}, 64'h00000000);
    issue(C_MSUB, 1, 0, 32'd1, 32'd1);
    wait_done(n);
    check("msub_lo", {32'b0, Lo}, 64'h00000015);

    pulse_reset();
    issue(C_MSUB, 1, 0, 32'd1, 32'd1);
    wait_done(n);
    check("msub_wrap_hi", {32'b0, Hi}, 64'hFFFFFFFF);
    check("msub_wrap_lo", {32'b0, Lo}, 64'hFFFFFFFF);

    // mul with Start attempts while busy, which must be ignored.
    issue(C_MUL, 0, 1, 32'd7, 32'hFFFFFFFD);
    issue(C_MTHI, 1, 0, 32'h00005555, 32'd0);
    issue(C_MULT, 1, 0, 32'd9, 32'd9);
    wait_done(n);
    check("mul_result", {32'b0, MulResult}, 64'hFFFFFFEB);
    check("mul_hi_kept", {32'b0, Hi}, 64'hFFFFFFFF);
    check("mul_lo_kept", {32'b0, Lo}, 64'hFFFFFFFF);
    issue(C_MTHI, 1, 0, 32'h00001234, 32'd0);
    check("mthi_hi", {32'b0, Hi}, 64'h00001234);

    // Back-to-back: second op is issued in the Done cycle of the first.
    issue(C_MULT, 1, 0, 32'd2, 32'd3);
    wait_done(n);
    check("b2b_first_lo", {32'b0, Lo}, 64'd6);
    issue(C_MUL, 0, 1, 32'h10, 32'h10);
    wait_done(n);
    check("b2b_latency", 64'(n), 64'd33);
    check("b2b_mulresult", {32'b0, MulResult}, 64'h100);

    // Reset in the middle of a multiply aborts it.
    issue(C_MULT, 1, 0, 32'd5, 32'hFFFFFFFA);
    repeat (9) @(negedge Clk);
    pulse_reset();
    check("abort_busy", {63'b0, Busy}, 64'd0);
    check("abort_hi", {32'b0, Hi}, 64'd0);
    check("abort_lo", {32'b0, Lo}, 64'd0);
    repeat (40) @(negedge Clk);
    issue(C_MULT, 1, 0, 32'd5, 32'hFFFFFFFA);
    wait_done(n);
    check("after_abort_hi", {32'b0, Hi}, 64'hFFFFFFFF);
    check("after_abort_lo", {32'b0, Lo}, 64'hFFFFFFE2);
    repeat (3) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
